// File: rtl/port_uart_tx.sv
// Port-0 serial transmitter: a small byte FIFO feeding an 8N1 frame generator,
// with a pollable status byte {busy, full, empty, ovr, count[3:0]}.
module port_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ovr_clr,
    output logic       tx,
    output logic [7:0] status
);
    localparam int BW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [3:0]    DEPTH_CNT = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic [3:0]    count_q, count_d;
    logic          ovr_q, ovr_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          wrAccept, pop, notEmpty;

    assign notEmpty = (count_q != 4'd0);
    assign wrAccept = wr_en && (count_q < DEPTH_CNT);

    // Frame generator; tx_d is the line level for the coming cycle, so the
    // start bit appears on the same edge that pops the byte.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (notEmpty) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rptr_q];
                    state_d = START;
                    bcnt_d  = BAUD_LAST;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bcnt_q == '0) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    bcnt_d  = BAUD_LAST;
                    tx_d    = sh_q[0];
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            DATA: begin
                if (bcnt_q == '0) begin
                    bcnt_d = BAUD_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[bit_q + 3'd1];
                    end
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            STOP: begin
                if (bcnt_q == '0) begin
                    if (notEmpty) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rptr_q];
                        state_d = START;
                        bcnt_d  = BAUD_LAST;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Occupancy and sticky overrun; a dropped write outranks a clear.
    always_comb begin
        count_d = count_q;
        if (wrAccept && !pop) begin
            count_d = count_q + 4'd1;
        end else if (!wrAccept && pop) begin
            count_d = count_q - 4'd1;
        end
        ovr_d = ovr_q;
        if (wr_en && !wrAccept) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            tx_q    <= 1'b1;
            count_q <= 4'd0;
            ovr_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            if (wrAccept) wptr_q <= wptr_q + PW'(1);
            if (pop)      rptr_q <= rptr_q + PW'(1);
        end
    end

    // Storage needs no reset: resetting the pointers and count flushes it.
    always_ff @(posedge clk) begin
        if (wrAccept) mem_q[wptr_q] <= wr_data;
    end

    assign tx     = tx_q;
    assign status = {(state_q != IDLE), (count_q == DEPTH_CNT), (count_q == 4'd0), ovr_q, count_q};

endmodule
